cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/result_fifo.sv | 69 ++++++
 rtl/cdb_arbiter.sv | 98 +++++++++
 tb/tb_cdb_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: requester indices and
// the {robId, value} result record held in each requester queue.
package cdb_arbiter_pkg;

    // Requester indices on the reqValid/reqRobId/reqVal buses
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSB = 1;
    localparam int unsigned REQ_BRU = 2;

    // Record widths; the rob field tracks the arbiter's default ROB_WIDTH
    localparam int unsigned RESULT_ROB_W = 4;
    localparam int unsigned VALUE_W      = 32;

    typedef struct packed {
        logic [RESULT_ROB_W-1:0] rob_id;
        logic [VALUE_W-1:0]      value;
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// Per-requester result queue of QDEPTH {robId, value} entries.
// Ports: clk/rst_n, flush (drops contents and same-cycle push), push + write
// data, pop, ready_c (count < QDEPTH), empty_c, head_rob_id_c/head_val_c.
module result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = RESULT_ROB_W,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic [ROB_WIDTH-1:0] wr_rob_id,
    input  logic [VALUE_W-1:0]   wr_val,
    input  logic                 pop,
    output logic                 ready_c,
    output logic                 empty_c,
    output logic [ROB_WIDTH-1:0] head_rob_id_c,
    output logic [VALUE_W-1:0]   head_val_c
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    result_t          mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push_c;
    logic             do_pop_c;

    // Ready comes from the registered count only, never from this cycle's pop
    assign ready_c       = (count < CNT_W'(QDEPTH));
    assign empty_c       = (count == '0);
    assign do_push_c     = push && ready_c && !flush;
    assign do_pop_c      = pop && !empty_c && !flush;
    assign head_rob_id_c = ROB_WIDTH'(mem[rd_ptr].rob_id);
    assign head_val_c    = mem[rd_ptr].value;

    // Pointer and occupancy tracking; pointers wrap naturally (QDEPTH is 2^n)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once it has been written
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= '{rob_id: RESULT_ROB_W'(wr_rob_id), value: wr_val};
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: queues results from NUM_REQ producers and
// broadcasts one per cycle, chosen round-robin from rrPtr.
// Ports: clockIn, resetIn (async, active-low), flushIn (sync mispredict
// flush), reqValid/reqRobId/reqVal (packed per requester, req 0 in LSBs),
// reqReady (per-requester space), cdbValid/cdbRobId/cdbVal/cdbSrc (broadcast).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = RESULT_ROB_W,
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic                         clockIn,
    input  logic                         resetIn,
    input  logic                         flushIn,
    input  logic [NUM_REQ-1:0]           reqValid,
    input  logic [NUM_REQ*ROB_WIDTH-1:0] reqRobId,
    input  logic [NUM_REQ*VALUE_W-1:0]   reqVal,
    output logic [NUM_REQ-1:0]           reqReady,
    output logic                         cdbValid,
    output logic [ROB_WIDTH-1:0]         cdbRobId,
    output logic [VALUE_W-1:0]           cdbVal,
    output logic [1:0]                   cdbSrc
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   empty_c;
    logic [NUM_REQ-1:0]   pop_c;
    logic [ROB_WIDTH-1:0] head_rob_c [NUM_REQ];
    logic [VALUE_W-1:0]   head_val_c [NUM_REQ];
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     cand_c;
    logic [IDX_W-1:0]     grant_idx_c;
    logic                 grant_valid_c;

    // One private queue per requester
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        result_fifo #(
            .ROB_WIDTH (ROB_WIDTH),
            .QDEPTH    (QDEPTH)
        ) u_fifo (
            .clk           (clockIn),
            .rst_n         (resetIn),
            .flush         (flushIn),
            .push          (reqValid[i]),
            .wr_rob_id     (reqRobId[i*ROB_WIDTH +: ROB_WIDTH]),
            .wr_val        (reqVal[i*VALUE_W +: VALUE_W]),
            .pop           (pop_c[i]),
            .ready_c       (reqReady[i]),
            .empty_c       (empty_c[i]),
            .head_rob_id_c (head_rob_c[i]),
            .head_val_c    (head_val_c[i])
        );
    end

    // Round-robin: first non-empty queue scanning upward from rr_ptr
    always_comb begin
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
        cand_c        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!grant_valid_c && !empty_c[cand_c]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = cand_c;
            end
        end
    end

    always_comb begin
        pop_c = '0;
        if (grant_valid_c) pop_c[grant_idx_c] = 1'b1;
    end

    // Broadcast register and round-robin pointer; data holds when idle
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            rr_ptr   <= IDX_W'(REQ_ALU);
            cdbValid <= 1'b0;
            cdbRobId <= '0;
            cdbVal   <= '0;
            cdbSrc   <= '0;
        end else if (flushIn) begin
            rr_ptr   <= '0;
            cdbValid <= 1'b0;
        end else begin
            cdbValid <= grant_valid_c;
            if (grant_valid_c) begin
                rr_ptr   <= IDX_W'((32'(grant_idx_c) + 32'd1) % NUM_REQ);
                cdbRobId <= head_rob_c[grant_idx_c];
                cdbVal   <= head_val_c[grant_idx_c];
                cdbSrc   <= 2'(grant_idx_c);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned ROB_WIDTH = 4;
    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned QDEPTH    = 2;

    logic                         clockIn = 1'b0;
    logic                         resetIn;
    logic                         flushIn;
    logic [NUM_REQ-1:0]           reqValid;
    logic [NUM_REQ*ROB_WIDTH-1:0] reqRobId;
    logic [NUM_REQ*32-1:0]        reqVal;
    logic [NUM_REQ-1:0]           reqReady;
    logic                         cdbValid;
    logic [ROB_WIDTH-1:0]         cdbRobId;
    logic [31:0]                  cdbVal;
    logic [1:0]                   cdbSrc;

    always #5 clockIn = ~clockIn;

    cdb_arbiter #(
        .ROB_WIDTH (ROB_WIDTH),
        .NUM_REQ   (NUM_REQ),
        .QDEPTH    (QDEPTH)
    ) dut (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .flushIn  (flushIn),
        .reqValid (reqValid),
        .reqRobId (reqRobId),
        .reqVal   (reqVal),
        .reqReady (reqReady),
        .cdbValid (cdbValid),
        .cdbRobId (cdbRobId),
        .cdbVal   (cdbVal),
        .cdbSrc   (cdbSrc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per requester and a round-robin start index
    result_t              mq [NUM_REQ][$];
    int                   rr;
    logic                 exp_valid;
    logic [ROB_WIDTH-1:0] exp_rob;
    logic [31:0]          exp_val;
    logic [1:0]           exp_src;
    logic [NUM_REQ-1:0]   exp_ready;
    logic [NUM_REQ-1:0]   last_acc;

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
        rr        = 0;
        exp_valid = 1'b0;
        exp_rob   = '0;
        exp_val   = '0;
        exp_src   = '0;
        exp_ready = '1;
        last_acc  = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] rob, input logic [31:0] val);
        reqValid[i] = v;
        reqRobId[i*ROB_WIDTH +: ROB_WIDTH] = rob;
        reqVal[i*32 +: 32] = val;
    endtask

    task automatic clear_reqs();
        reqValid = '0;
        reqRobId = '0;
        reqVal   = '0;
        flushIn  = 1'b0;
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUT
    task automatic tick();
        int g;
        logic [NUM_REQ-1:0] acc;
        acc = '0;
        if (flushIn) begin
            for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
            rr        = 0;
            exp_valid = 1'b0;
        end else begin
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (rr + k) % NUM_REQ;
                if (g < 0 && mq[idx].size() > 0) g = idx;
            end
            for (int i = 0; i < NUM_REQ; i++)
                acc[i] = reqValid[i] && (mq[i].size() < QDEPTH);
            if (g >= 0) begin
                result_t r;
                r         = mq[g].pop_front();
                exp_valid = 1'b1;
                exp_rob   = r.rob_id;
                exp_val   = r.value;
                exp_src   = 2'(g);
                rr        = (g + 1) % NUM_REQ;
            end else begin
                exp_valid = 1'b0;
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (acc[i]) mq[i].push_back('{rob_id: reqRobId[i*ROB_WIDTH +: ROB_WIDTH], value: reqVal[i*32 +: 32]});
        end
        last_acc = acc;
        @(posedge clockIn);
        #1;
        for (int i = 0; i < NUM_REQ; i++) exp_ready[i] = (mq[i].size() < QDEPTH);
    endtask

    task automatic hard_reset();
        clear_reqs();
        resetIn = 1'b0;
        @(posedge clockIn);
        #1;
        resetIn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        clear_reqs();
        resetIn = 1'b0;
        repeat (2) @(posedge clockIn);
        #1;
        n_cmp++; if (cdbValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", cdbValid); end
        n_cmp++; if (cdbRobId !== 4'd0) begin n_bad++; $display("FAIL reset_rob got=%0d exp=0", cdbRobId); end
        n_cmp++; if (cdbVal !== 32'd0) begin n_bad++; $display("FAIL reset_val got=%h exp=0", cdbVal); end
        n_cmp++; if (cdbSrc !== 2'd0) begin n_bad++; $display("FAIL reset_src got=%0d exp=0", cdbSrc); end
        resetIn = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (reqReady !== 3'b111) begin n_bad++; $display("FAIL reset_ready got=%b exp=111", reqReady); end
    endtask

    task automatic test_single();
        set_req(REQ_ALU, 1'b1, 4'd3, 32'h0000002A);
        tick();
        clear_reqs();
        n_cmp++; if (cdbValid !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass got=%b exp=0", cdbValid); end
        tick();
        n_cmp++; if (cdbValid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", cdbValid); end
        n_cmp++; if (cdbRobId !== 4'd3) begin n_bad++; $display("FAIL single_rob got=%0d exp=3", cdbRobId); end
        n_cmp++; if (cdbVal !== 32'h2A) begin n_bad++; $display("FAIL single_val got=%h exp=2a", cdbVal); end
        n_cmp++; if (cdbSrc !== 2'd0) begin n_bad++; $display("FAIL single_src got=%0d exp=0", cdbSrc); end
        tick();
        n_cmp++; if (cdbValid !== 1'b0) begin n_bad++; $display("FAIL single_once got=%b exp=0", cdbValid); end
        n_cmp++; if (cdbRobId !== 4'd3) begin n_bad++; $display("FAIL single_hold_rob got=%0d exp=3", cdbRobId); end
    endtask

    task automatic test_contention();
        hard_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 4'(i + 1), 32'h100 + 32'(i));
        tick();
        clear_reqs();
        for (int k = 0; k < NUM_REQ; k++) begin
            tick();
            n_cmp++; if (cdbValid !== 1'b1 || cdbRobId !== 4'(k + 1) || cdbSrc !== 2'(k))
                begin n_bad++; $display("FAIL contention_%0d got v=%b rob=%0d src=%0d exp v=1 rob=%0d src=%0d", k, cdbValid, cdbRobId, cdbSrc, k + 1, k); end
        end
        tick();
        n_cmp++; if (cdbValid !== 1'b0) begin n_bad++; $display("FAIL contention_idle got=%b exp=0", cdbValid); end
    endtask

    task automatic test_back_pressure();
        result_t seen[$];
        int lsb_n;
        lsb_n = 0;
        hard_reset();
        for (int c = 0; c < 30; c++) begin
            if (c < 15) begin
                set_req(REQ_ALU, 1'b1, 4'($urandom), $urandom);
                set_req(REQ_BRU, 1'b1, 4'($urandom), $urandom);
            end else begin
                set_req(REQ_ALU, 1'b0, '0, '0);
                set_req(REQ_BRU, 1'b0, '0, '0);
            end
            if (lsb_n < 3) set_req(REQ_LSB, 1'b1, 4'(5 + lsb_n), 32'h200 + 32'(lsb_n));
            else           set_req(REQ_LSB, 1'b0, '0, '0);
            tick();
            if (last_acc[REQ_LSB]) begin
                lsb_n++;
                if (lsb_n == 2) begin
                    n_cmp++; if (reqReady[REQ_LSB] !== 1'b0) begin n_bad++; $display("FAIL bp_lsb_full got=%b exp=0", reqReady[REQ_LSB]); end
                end
            end
            n_cmp++; if (cdbValid !== exp_valid) begin n_bad++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, cdbValid, exp_valid); end
            n_cmp++; if (reqReady !== exp_ready) begin n_bad++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, reqReady, exp_ready); end
            if (cdbValid && cdbSrc == 2'(REQ_LSB)) seen.push_back('{rob_id: cdbRobId, value: cdbVal});
        end
        clear_reqs();
        n_cmp++; if (seen.size() != 3) begin n_bad++; $display("FAIL bp_lsb_count got=%0d exp=3", seen.size()); end
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            n_cmp++; if (seen[k].rob_id !== 4'(5 + k) || seen[k].value !== 32'h200 + 32'(k))
                begin n_bad++; $display("FAIL bp_lsb_order_%0d got rob=%0d val=%h exp rob=%0d val=%h", k, seen[k].rob_id, seen[k].value, 5 + k, 32'h200 + 32'(k)); end
        end
    endtask

    task automatic test_flush();
        set_req(REQ_ALU, 1'b1, 4'd8, 32'h11);
        set_req(REQ_BRU, 1'b1, 4'd9, 32'h22);
        tick();
        clear_reqs();
        flushIn = 1'b1;
        set_req(REQ_ALU, 1'b1, 4'hA, 32'hDEAD);
        tick();
        clear_reqs();
        n_cmp++; if (cdbValid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", cdbValid); end
        n_cmp++; if (reqReady !== 3'b111) begin n_bad++; $display("FAIL flush_empty got=%b exp=111", reqReady); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (cdbValid !== 1'b0) begin n_bad++; $display("FAIL flush_stale c=%0d got v=%b rob=%0d exp v=0", c, cdbValid, cdbRobId); end
        end
    endtask

    task automatic test_fairness();
        int n;
        bit found;
        found = 1'b0;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            set_req(REQ_ALU, 1'b1, 4'(c), 32'h300 + 32'(c));
            tick();
        end
        set_req(REQ_ALU, 1'b1, 4'd3, 32'h303);
        set_req(REQ_LSB, 1'b1, 4'd12, 32'hF00D);
        tick();
        set_req(REQ_LSB, 1'b0, '0, '0);
        while (!found && n < 6) begin
            set_req(REQ_ALU, 1'b1, 4'(n), 32'h400 + 32'(n));
            tick();
            n++;
            if (cdbValid && cdbSrc == 2'(REQ_LSB)) found = 1'b1;
        end
        n_cmp++; if (!found || n > 2) begin n_bad++; $display("FAIL fairness_wait got found=%b cycles=%0d exp found=1 cycles<=2", found, n); end
        n_cmp++; if (cdbRobId !== 4'd12 || cdbVal !== 32'hF00D) begin n_bad++; $display("FAIL fairness_data got rob=%0d val=%h exp rob=12 val=f00d", cdbRobId, cdbVal); end
        clear_reqs();
        repeat (4) tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 4'(i + 4), 32'h500 + 32'(i));
        tick();
        clear_reqs();
        tick();
        n_cmp++; if (cdbValid !== 1'b1) begin n_bad++; $display("FAIL areset_pre got=%b exp=1", cdbValid); end
        #3;
        resetIn = 1'b0;
        #1;
        n_cmp++; if (cdbValid !== 1'b0) begin n_bad++; $display("FAIL areset_async_valid got=%b exp=0", cdbValid); end
        n_cmp++; if (cdbVal !== 32'd0) begin n_bad++; $display("FAIL areset_async_val got=%h exp=0", cdbVal); end
        @(posedge clockIn);
        #1;
        resetIn = 1'b1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (cdbValid !== 1'b0) begin n_bad++; $display("FAIL areset_stale c=%0d got=%b exp=0", c, cdbValid); end
            n_cmp++; if (reqReady !== 3'b111) begin n_bad++; $display("FAIL areset_ready c=%0d got=%b exp=111", c, reqReady); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                logic v;
                v = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                set_req(i, v, 4'($urandom), $urandom);
            end
            flushIn = ($urandom_range(0, 31) == 0);
            tick();
            n_cmp++; if (cdbValid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, cdbValid, exp_valid); end
            n_cmp++; if (cdbRobId !== exp_rob) begin n_bad++; $display("FAIL rnd_rob c=%0d got=%0d exp=%0d", c, cdbRobId, exp_rob); end
            n_cmp++; if (cdbVal !== exp_val) begin n_bad++; $display("FAIL rnd_val c=%0d got=%h exp=%h", c, cdbVal, exp_val); end
            n_cmp++; if (cdbSrc !== exp_src) begin n_bad++; $display("FAIL rnd_src c=%0d got=%0d exp=%0d", c, cdbSrc, exp_src); end
            n_cmp++; if (reqReady !== exp_ready) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, reqReady, exp_ready); end
        end
        clear_reqs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_reqs();
        resetIn = 1'b1;
        model_reset();
        #2;
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_flush();
        test_fairness();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
